rv32e_mem_resp: RTL and testbench

RV32E_MEM_RESP -- requirements
Module: rv32e_mem_resp

---
 rtl/rv32e_pkg.sv | 32 +++
 rtl/rv32e_mem_array.sv | 32 +++
 rtl/rv32e_mem_resp.sv | 113 +++++++++++
 tb/tb_rv32e_mem_resp.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// Shared types and constants for the RV32E memory responder.
// Holds the FSM state enum, XLEN, strobe width and the fault check.
package rv32e_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_fault(
    input logic [XLEN-1:0] addr,
    input int unsigned     depth
  );
    logic [XLEN-1:0] word;
    word = {2'b00, addr[XLEN-1:2]};
    return (addr[1:0] != 2'b00) || (word >= depth);
  endfunction

endpackage

// File: rtl/rv32e_mem_array.sv
// Byte-enabled single-port word RAM: synchronous write, async read.
// Ports: clk; we/addr/wdata/wstrb write side; rdata word at addr.
module rv32e_mem_array
  import rv32e_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/rv32e_mem_resp.sv
// Memory responder for an RV32E core: one request at a time,
// IDLE -> WAIT (WAIT_CYCLES) -> RESP, with fault detection.
// Ports: clk, reset (sync, active-high);
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb;
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err.
module rv32e_mem_resp
  import rv32e_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t          state;
  logic [CNT_W-1:0] cnt;

  req_t            req;
  logic            accept;
  logic            fault;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  assign req = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    wstrb: req_wstrb
  };

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign fault     = addr_fault(req.addr, DEPTH_WORDS);

  // A store coinciding with reset is dropped along with the request.
  assign mem_we = accept && req.we && !fault && !reset;

  rv32e_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (req.addr[AW+1:2]),
    .wdata (req.wdata),
    .wstrb (req.wstrb),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            // Response is captured now so later stores
            // cannot disturb it.
            rsp_err   <= fault;
            rsp_rdata <= (fault || req.we) ? '0 : mem_rdata;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32e_mem_resp.sv
// Self-checking bench for rv32e_mem_resp: two instances
// (WAIT_CYCLES=1 / 1024 words, WAIT_CYCLES=0 / 16 words).
module tb_rv32e_mem_resp;

  localparam int W0 = 1;
  localparam int D0 = 1024;
  localparam int W1 = 0;
  localparam int D1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  rv32e_mem_resp #(
    .DEPTH_WORDS(D0),
    .WAIT_CYCLES(W0)
  ) dut0 (
    .clk       (clk),
    .reset     (rst[0]),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_wstrb (req_wstrb[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  rv32e_mem_resp #(
    .DEPTH_WORDS(D1),
    .WAIT_CYCLES(W1)
  ) dut1 (
    .clk       (clk),
    .reset     (rst[1]),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_wstrb (req_wstrb[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  // Behavioural model: a word memory per instance, and one
  // outstanding request stamped with the edge it was taken on.
  logic [31:0] mmem [2][D0];
  bit          m_busy  [2];
  int          m_tacc  [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  bit          m_rst   [2];
  int          cyc = 0;
  int          n_rsp [2] = '{0, 0};
  int          obs   [2] = '{0, 0};

  function automatic int wc(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int dp(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic bit flt(input int i);
    return (req_addr[i][1:0] != 2'b00) ||
           ((req_addr[i] >> 2) >= 32'(dp(i)));
  endfunction

  function automatic int widx(input int i);
    return int'(req_addr[i][11:2]);
  endfunction

  // Response visible 1+W edges after acceptance.
  function automatic bit exp_valid(input int i);
    return m_busy[i] && (cyc >= m_tacc[i] + wc(i));
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      m_rst[i] <= rst[i];
      if (rst[i]) begin
        m_busy[i] <= 1'b0;
      end else if (!m_busy[i]) begin
        if (req_valid[i]) begin
          m_busy[i]  <= 1'b1;
          m_tacc[i]  <= cyc + 1;
          m_err[i]   <= flt(i);
          m_rdata[i] <= (flt(i) || req_we[i]) ? 32'd0
                        : mmem[i][widx(i)];
          if (!flt(i) && req_we[i]) begin
            for (int b = 0; b < 4; b++) begin
              if (req_wstrb[i][b]) begin
                mmem[i][widx(i)][8*b +: 8] <=
                  req_wdata[i][8*b +: 8];
              end
            end
          end
        end
      end else if (exp_valid(i) && rsp_ready[i]) begin
        m_busy[i] <= 1'b0;
        n_rsp[i]  <= n_rsp[i] + 1;
      end
      if (!rst[i] && rsp_valid[i] === 1'b1 && rsp_ready[i]) begin
        obs[i] <= obs[i] + 1;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req_ready[%0d]", i),
          32'(req_ready[i]), 32'(!m_busy[i]));
      chk($sformatf("rsp_valid[%0d]", i),
          32'(rsp_valid[i]), 32'(exp_valid(i)));
      if (exp_valid(i)) begin
        chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], m_rdata[i]);
        chk($sformatf("rsp_err[%0d]", i),
            32'(rsp_err[i]), 32'(m_err[i]));
      end
      if (m_rst[i]) begin
        chk($sformatf("rst rdata[%0d]", i), rsp_rdata[i], 32'd0);
        chk($sformatf("rst err[%0d]", i), 32'(rsp_err[i]), 32'd0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic req_op(input int i, input bit we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s,
                        input int hold,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
    rsp_ready[i] = (hold == 0);
    tick();
    // Junk on the request bus while busy must be ignored.
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_wstrb[i] = 4'($urandom);
    lat = 1;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp arrives", 32'(rsp_valid[i]), 32'd1);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold valid", 32'(rsp_valid[i]), 32'd1);
      chk("hold req_ready", 32'(req_ready[i]), 32'd0);
      chk("hold rdata", rsp_rdata[i], rd);
    end
    rsp_ready[i] = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] pick(input int i);
    int r;
    int w;
    r = $urandom_range(0, 9);
    if (i == 0) begin
      w = $urandom_range(0, 32);
      if (w == 32) w = D0 - 1;
    end else begin
      w = $urandom_range(0, 15);
    end
    if (r < 7) return 32'(4 * w);
    if (r == 7) return 32'(4 * w + $urandom_range(1, 3));
    if (r == 8) return 32'(4 * dp(i) + 4 * $urandom_range(0, 7));
    return $urandom | 32'h8000_0000;
  endfunction

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          cnt;
  int          base;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_wstrb[i] = '0;
      rsp_ready[i] = 1'b1;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    for (int w = 0; w < 32; w++)
      req_op(0, 1, 32'(4 * w), $urandom, 4'hF, 0, rd, er, lat);
    req_op(0, 1, 32'(4 * (D0 - 1)), $urandom, 4'hF, 0, rd, er, lat);
    chk("last word err", 32'(er), 32'd0);
    for (int w = 0; w < D1; w++)
      req_op(1, 1, 32'(4 * w), $urandom, 4'hF, 0, rd, er, lat);

    req_op(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    chk("store err", 32'(er), 32'd0);
    chk("store rdata", rd, 32'd0);
    req_op(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    chk("load latency W=1", 32'(lat), 32'd2);
    chk("load beef", rd, 32'hDEAD_BEEF);
    chk("load beef err", 32'(er), 32'd0);

    req_op(0, 1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rd, er, lat);
    req_op(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    chk("byte merge", rd, 32'hDEAD_BEAA);

    req_op(0, 0, 32'h12, 32'd0, 4'h0, 0, rd, er, lat);
    chk("misaligned err", 32'(er), 32'd1);
    chk("misaligned rdata", rd, 32'd0);
    req_op(0, 0, 32'(4 * D0), 32'd0, 4'h0, 0, rd, er, lat);
    chk("range err", 32'(er), 32'd1);
    chk("range rdata", rd, 32'd0);
    req_op(0, 1, 32'h12, 32'h1122_3344, 4'hF, 0, rd, er, lat);
    chk("bad store err", 32'(er), 32'd1);
    req_op(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
    chk("strb0 err", 32'(er), 32'd0);
    req_op(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
    chk("mem unchanged", rd, 32'hDEAD_BEAA);

    base = obs[0];
    req_op(0, 0, 32'h10, 32'd0, 4'h0, 5, rd, er, lat);
    chk("hold data", rd, 32'hDEAD_BEAA);
    chk("hold one rsp", 32'(obs[0] - base), 32'd1);

    req_op(0, 1, 32'h20, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h20;
    tick();
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("wait rst valid", 32'(rsp_valid[0]), 32'd0);
    chk("wait rst ready", 32'(req_ready[0]), 32'd1);
    tick();
    tick();
    chk("no late rsp", 32'(rsp_valid[0]), 32'd0);
    rst[0]       = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'd0;
    req_wstrb[0] = 4'hF;
    tick();
    rst[0]       = 1'b0;
    req_valid[0] = 1'b0;
    tick();
    req_op(0, 0, 32'h20, 32'd0, 4'h0, 0, rd, er, lat);
    chk("survives reset", rd, 32'h1234_5678);

    req_op(1, 0, 32'h4, 32'd0, 4'h0, 0, rd, er, lat);
    chk("load latency W=0", 32'(lat), 32'd1);
    base = obs[1];
    cnt  = 0;
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 32'(4 * $urandom_range(0, 15));
      tick();
      if (rsp_valid[1] === 1'b1) cnt++;
    end
    req_valid[1] = 1'b0;
    tick();
    chk("b2b valid cycles", 32'(cnt), 32'd10);
    chk("b2b responses", 32'(obs[1] - base), 32'd10);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]       = ($urandom_range(0, 99) == 0);
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_we[i]    = 1'($urandom);
        req_addr[i]  = pick(i);
        req_wdata[i] = $urandom;
        req_wstrb[i] = 4'($urandom);
        rsp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b0;
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
    tick();
    tick();
    tick();
    chk("rsp count 0", 32'(obs[0]), 32'(n_rsp[0]));
    chk("rsp count 1", 32'(obs[1]), 32'(n_rsp[1]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
